// File: rtl/id_token_fsm.sv
// Streaming identifier recognizer: one character per accepted cycle, registered
// legality flag, saturating token length, overflow flag and completed-token count.
// Defining ID_TOKEN_PULSE_EN adds the tok_done completion pulse output.
module id_token_fsm #(
    parameter int unsigned CHAR_W  = 8,
    parameter int unsigned MODE    = 0,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] char,
    input  logic              clr,
    output logic              out,
    output logic [LEN_W-1:0]  id_len,
    output logic              len_ovf,
    output logic [CNT_W-1:0]  tok_cnt
`ifdef ID_TOKEN_PULSE_EN
    ,
    output logic              tok_done
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LET,
        ST_DIG,
        ST_IN_ID,
        ST_BAD
    } state_t;

    typedef enum logic [1:0] {
        CL_L,
        CL_D,
        CL_U,
        CL_O
    } cls_t;

    typedef enum logic [1:0] {
        LA_ZERO,
        LA_ONE,
        LA_INC
    } len_act_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    cls_t             cls_c;
    len_act_t         act_c;
    logic [7:0]       ascii;
    logic             hi_nz;
    logic             accept_c;
    logic             out_d;
    logic [LEN_W-1:0] len_d;
    logic             ovf_d;
    logic [CNT_W-1:0] cnt_d;
    logic             inc_c;

    assign ascii = char[7:0];

    // Anything with bits set above the ASCII byte is an "other" character.
    generate
        if (CHAR_W > 8) begin : g_hi
            assign hi_nz = |char[CHAR_W-1:8];
        end else begin : g_no_hi
            assign hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin : p_class
        cls_c = CL_O;
        if (!hi_nz) begin
            if ((ascii >= 8'd65 && ascii <= 8'd90) || (ascii >= 8'd97 && ascii <= 8'd122)) begin
                cls_c = CL_L;
            end else if (ascii >= 8'd48 && ascii <= 8'd57) begin
                cls_c = CL_D;
            end else if (ascii == 8'd95) begin
                cls_c = CL_U;
            end
        end
    end

    // Next state, next registered outputs and completion detect.
    always_comb begin : p_next
        state_d  = state_q;
        act_c    = LA_ZERO;
        accept_c = 1'b0;
        out_d    = out;
        len_d    = id_len;
        ovf_d    = len_ovf;
        cnt_d    = tok_cnt;
        inc_c    = 1'b0;

        if (in_valid) begin
            if (MODE == 0) begin
                case (cls_c)
                    CL_L: begin
                        state_d = ST_LET;
                        act_c   = (state_q == ST_LET) ? LA_INC : LA_ONE;
                    end
                    CL_D: begin
                        if (state_q == ST_LET || state_q == ST_DIG) begin
                            state_d = ST_DIG;
                            act_c   = LA_INC;
                        end else begin
                            state_d = ST_IDLE;
                            act_c   = LA_ZERO;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        act_c   = LA_ZERO;
                    end
                endcase
                accept_c = (state_d == ST_DIG);
            end else begin
                if (cls_c == CL_O) begin
                    state_d = ST_IDLE;
                    act_c   = LA_ZERO;
                end else begin
                    case (state_q)
                        ST_IN_ID: begin
                            state_d = ST_IN_ID;
                            act_c   = LA_INC;
                        end
                        ST_BAD: begin
                            state_d = ST_BAD;
                            act_c   = LA_ZERO;
                        end
                        default: begin
                            if (cls_c == CL_D) begin
                                state_d = ST_BAD;
                                act_c   = LA_ZERO;
                            end else begin
                                state_d = ST_IN_ID;
                                act_c   = LA_ONE;
                            end
                        end
                    endcase
                end
                accept_c = (state_d == ST_IN_ID);
            end

            // Growing past MAX_LEN pins the length and raises overflow until the token ends.
            case (act_c)
                LA_ONE: begin
                    len_d = LEN_ONE;
                    ovf_d = 1'b0;
                end
                LA_INC: begin
                    if (len_ovf || id_len == LEN_MAX) begin
                        len_d = LEN_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        len_d = id_len + LEN_ONE;
                    end
                end
                default: begin
                    len_d = '0;
                    ovf_d = 1'b0;
                end
            endcase

            out_d = accept_c && !ovf_d;
            inc_c = out && !out_d && !ovf_d;
            if (inc_c && !(&tok_cnt)) begin
                cnt_d = tok_cnt + CNT_ONE;
            end
        end

        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (!reset_n) begin
            state_q <= ST_IDLE;
            out     <= 1'b0;
            id_len  <= '0;
            len_ovf <= 1'b0;
            tok_cnt <= '0;
        end else begin
            state_q <= state_d;
            out     <= out_d;
            id_len  <= len_d;
            len_ovf <= ovf_d;
            tok_cnt <= cnt_d;
        end
    end

`ifdef ID_TOKEN_PULSE_EN
    // Pulses on every terminator-caused completion, independent of saturation or clr.
    always_ff @(posedge clk) begin : p_done
        if (!reset_n) begin
            tok_done <= 1'b0;
        end else begin
            tok_done <= inc_c;
        end
    end
`endif

endmodule

// File: tb/tb_id_token_fsm.sv
// Bench for id_token_fsm: four configurations share one stimulus stream and are
// compared against a suffix-based reference model of the token grammar.
module tb_id_token_fsm;

    localparam int C_L = 0;
    localparam int C_D = 1;
    localparam int C_U = 2;
    localparam int C_O = 3;
    localparam int HCAP = 300;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       clr;
    logic [9:0] ch;

    logic       out0, out1, out2, out3;
    logic [4:0] len0, len2;
    logic [2:0] len1, len3;
    logic       ovf0, ovf1, ovf2, ovf3;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1, cnt3;
`ifdef ID_TOKEN_PULSE_EN
    logic       done0, done1, done2, done3;
`endif

    int errors = 0;
    int checks = 0;

    int          h8[$];
    int          h10[$];
    int unsigned m_len[4];
    bit          m_ovf[4];
    bit          m_out[4];
    int unsigned m_cnt[4];
    bit          m_done[4];

    always #5 clk = ~clk;

    id_token_fsm #(.CHAR_W(8), .MODE(0), .MAX_LEN(16), .LEN_W(5), .CNT_W(8)) u_d0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .char(ch[7:0]), .clr(clr),
        .out(out0), .id_len(len0), .len_ovf(ovf0), .tok_cnt(cnt0)
`ifdef ID_TOKEN_PULSE_EN
        , .tok_done(done0)
`endif
    );

    id_token_fsm #(.CHAR_W(8), .MODE(1), .MAX_LEN(4), .LEN_W(3), .CNT_W(2)) u_d1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .char(ch[7:0]), .clr(clr),
        .out(out1), .id_len(len1), .len_ovf(ovf1), .tok_cnt(cnt1)
`ifdef ID_TOKEN_PULSE_EN
        , .tok_done(done1)
`endif
    );

    id_token_fsm #(.CHAR_W(10), .MODE(1), .MAX_LEN(16), .LEN_W(5), .CNT_W(8)) u_d2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .char(ch), .clr(clr),
        .out(out2), .id_len(len2), .len_ovf(ovf2), .tok_cnt(cnt2)
`ifdef ID_TOKEN_PULSE_EN
        , .tok_done(done2)
`endif
    );

    id_token_fsm #(.CHAR_W(8), .MODE(0), .MAX_LEN(4), .LEN_W(3), .CNT_W(2)) u_d3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .char(ch[7:0]), .clr(clr),
        .out(out3), .id_len(len3), .len_ovf(ovf3), .tok_cnt(cnt3)
`ifdef ID_TOKEN_PULSE_EN
        , .tok_done(done3)
`endif
    );

    function automatic int mode_of(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    function automatic int maxlen_of(input int i);
        return (i == 1 || i == 3) ? 4 : 16;
    endfunction

    function automatic int unsigned cntmax_of(input int i);
        return (i == 1 || i == 3) ? 3 : 255;
    endfunction

    function automatic int cls(input int unsigned c);
        if ((c >= 65 && c <= 90) || (c >= 97 && c <= 122)) return C_L;
        if (c >= 48 && c <= 57) return C_D;
        if (c == 95) return C_U;
        return C_O;
    endfunction

    // Token = longest legal-shaped suffix of the consumed stream.
    // Mode 0: suffix of the form letters+ digits*; mode 1: run of [A-Za-z0-9_] not starting with a digit.
    function automatic void eval(input int mode, input int maxlen, input int q[$],
                                 output int unsigned len, output bit ovf, output bit outv);
        int n = 0;
        int k = 0;
        int m = 0;
        int idx;
        idx  = q.size() - 1;
        len  = 0;
        ovf  = 1'b0;
        outv = 1'b0;
        if (mode == 0) begin
            while (idx >= 0 && q[idx] == C_D) begin k++; idx--; end
            while (idx >= 0 && q[idx] == C_L) begin m++; idx--; end
            n    = (m > 0) ? k + m : 0;
            len  = (n > maxlen) ? maxlen : n;
            ovf  = (n > maxlen);
            outv = (k > 0) && (m > 0) && !ovf;
        end else begin
            while (idx >= 0 && q[idx] != C_O) begin n++; idx--; end
            if (n > 0 && q[idx+1] != C_D) begin
                len  = (n > maxlen) ? maxlen : n;
                ovf  = (n > maxlen);
                outv = !ovf;
            end
        end
    endfunction

    task automatic model_reset();
        h8.delete();
        h10.delete();
        for (int i = 0; i < 4; i++) begin
            m_len[i] = 0; m_ovf[i] = 0; m_out[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input int unsigned c, input bit cl);
        int unsigned nl;
        bit          no, nv, inc;
        for (int i = 0; i < 4; i++) m_done[i] = 1'b0;
        if (v) begin
            h8.push_back(cls(c & 255));
            h10.push_back(cls(c));
            if (h8.size() > HCAP) void'(h8.pop_front());
            if (h10.size() > HCAP) void'(h10.pop_front());
            for (int i = 0; i < 4; i++) begin
                if (i == 2) eval(mode_of(i), maxlen_of(i), h10, nl, no, nv);
                else        eval(mode_of(i), maxlen_of(i), h8, nl, no, nv);
                inc       = m_out[i] && !nv && !no;
                m_done[i] = inc;
                if (inc && m_cnt[i] < cntmax_of(i)) m_cnt[i]++;
                m_len[i] = nl;
                m_ovf[i] = no;
                m_out[i] = nv;
            end
        end
        if (cl) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check(input string tag);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] g_out, g_len, g_ovf, g_cnt;
            case (i)
                0: begin g_out = 32'(out0); g_len = 32'(len0); g_ovf = 32'(ovf0); g_cnt = 32'(cnt0); end
                1: begin g_out = 32'(out1); g_len = 32'(len1); g_ovf = 32'(ovf1); g_cnt = 32'(cnt1); end
                2: begin g_out = 32'(out2); g_len = 32'(len2); g_ovf = 32'(ovf2); g_cnt = 32'(cnt2); end
                default: begin g_out = 32'(out3); g_len = 32'(len3); g_ovf = 32'(ovf3); g_cnt = 32'(cnt3); end
            endcase
            chk($sformatf("%s d%0d out", tag, i), g_out, 32'(m_out[i]));
            chk($sformatf("%s d%0d id_len", tag, i), g_len, 32'(m_len[i]));
            chk($sformatf("%s d%0d len_ovf", tag, i), g_ovf, 32'(m_ovf[i]));
            chk($sformatf("%s d%0d tok_cnt", tag, i), g_cnt, 32'(m_cnt[i]));
`ifdef ID_TOKEN_PULSE_EN
            begin
                logic [31:0] g_done;
                case (i)
                    0: g_done = 32'(done0);
                    1: g_done = 32'(done1);
                    2: g_done = 32'(done2);
                    default: g_done = 32'(done3);
                endcase
                chk($sformatf("%s d%0d tok_done", tag, i), g_done, 32'(m_done[i]));
            end
`endif
        end
    endtask

    task automatic step(input bit v, input int unsigned c, input bit cl, input string tag);
        in_valid = v;
        ch       = 10'(c);
        clr      = cl;
        @(posedge clk);
        model_edge(v, c, cl);
        #1;
        check(tag);
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic feed(input string s, input string tag);
        for (int k = 0; k < s.len(); k++) step(1'b1, 32'(s[k]), 1'b0, tag);
    endtask

    // Reset wins even with a valid character presented on the same edge.
    task automatic do_reset(input string tag);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        ch       = 10'd97;
        clr      = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check(tag);
        reset_n  = 1'b1;
        in_valid = 1'b0;
    endtask

    function automatic int unsigned rand_char();
        int unsigned r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    return 97 + $urandom_range(0, 25);
            2:       return 65 + $urandom_range(0, 25);
            3, 4:    return 48 + $urandom_range(0, 9);
            5:       return 95;
            6:       return 32;
            7:       return 43;
            8:       return $urandom_range(0, 1023);
            default: return 256 + 97 + $urandom_range(0, 25);
        endcase
    endfunction

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        ch       = '0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        check("init_reset");
        reset_n = 1'b1;

        feed("ab12 ", "mode0_basic");
        chk("mode0_basic d0 tok_cnt const", 32'(cnt0), 32'd1);
        chk("mode0_basic d0 id_len const", 32'(len0), 32'd0);

        do_reset("rst2");
        feed("1a3c", "mode0_restart");
        chk("mode0_restart d0 id_len const", 32'(len0), 32'd1);
        chk("mode0_restart d0 out const", 32'(out0), 32'd0);
        feed("4", "mode0_restart");
        chk("mode0_restart d0 out4 const", 32'(out0), 32'd1);
        chk("mode0_restart d0 tok_cnt const", 32'(cnt0), 32'd1);

        do_reset("rst3");
        feed("_x9+9q+", "mode1_basic");
        chk("mode1_basic d1 tok_cnt const", 32'(cnt1), 32'd1);
        chk("mode1_basic d2 tok_cnt const", 32'(cnt2), 32'd1);

        do_reset("rst4");
        feed("abcde", "mode1_ovf");
        chk("mode1_ovf d1 id_len const", 32'(len1), 32'd4);
        chk("mode1_ovf d1 len_ovf const", 32'(ovf1), 32'd1);
        chk("mode1_ovf d1 out const", 32'(out1), 32'd0);
        feed(";", "mode1_ovf");
        chk("mode1_ovf d1 tok_cnt const", 32'(cnt1), 32'd0);

        do_reset("rst5");
        feed("a", "gap");
        repeat (3) step(1'b0, 32'd49, 1'b0, "gap_hold");
        chk("gap d0 id_len hold const", 32'(len0), 32'd1);
        feed("1", "gap");
        chk("gap d0 out const", 32'(out0), 32'd1);
        chk("gap d0 id_len const", 32'(len0), 32'd2);

        do_reset("rst6");
        feed("ab1", "clr_term");
        step(1'b1, 32'd32, 1'b1, "clr_term");
        chk("clr_term d0 tok_cnt const", 32'(cnt0), 32'd0);
`ifdef ID_TOKEN_PULSE_EN
        chk("clr_term d0 tok_done const", 32'(done0), 32'd1);
`endif
        feed("x9 y7 ", "clr_idle");
        step(1'b0, 32'd97, 1'b1, "clr_idle");

        do_reset("rst7");
        feed("ab1", "mid_rst");
        do_reset("mid_rst_reset");
        chk("mid_rst d0 out const", 32'(out0), 32'd0);
        feed("1", "mid_rst_after");

        do_reset("rst8");
        for (int t = 0; t < 5; t++) feed("a1 ", "sat");
        chk("sat d3 tok_cnt const", 32'(cnt3), 32'd3);
        chk("sat d0 tok_cnt const", 32'(cnt0), 32'd5);
        feed("abcdefghijklmnopq12 ", "long");

        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rand_reset");
            end else begin
                step(($urandom_range(0, 3) != 0), rand_char(), ($urandom_range(0, 39) == 0), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
